coin_button_conditioner: RTL and testbench

Front-end input stage of the vending machine. It synchronises and debounces the four coin switches and the L/R/C push-buttons, then turns clean rising edges into single-cycle events. The selection/credit FSM downstream consumes `coin_valid`/`coin_value` as credit increments and `l_pulse`/`r_pulse`/`c_pulse` as navigate/confirm strobes. This replaces raw level sampling, which adds credit on every clock a switch is held.

---
 rtl/vm_pkg.sv | 46 ++++
 rtl/coin_button_conditioner_if.sv | 28 ++
 rtl/debounce_cell.sv | 47 ++++
 rtl/coin_button_conditioner.sv | 203 ++++++++++++++++++++
 tb/tb_coin_button_conditioner.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine package: coin denominations, button indices,
// auto-repeat phase encoding and the price table used by the downstream
// selection/credit FSM.
package vm_pkg;

  localparam int unsigned COIN_VALUE_W = 5;
  localparam int unsigned NUM_COINS    = 4;
  localparam int unsigned BTN_BASE     = NUM_COINS;
  localparam int unsigned NUM_INPUTS   = NUM_COINS + 3;

  localparam logic [COIN_VALUE_W-1:0] COIN_V0 = 5'd1;
  localparam logic [COIN_VALUE_W-1:0] COIN_V1 = 5'd5;
  localparam logic [COIN_VALUE_W-1:0] COIN_V2 = 5'd10;
  localparam logic [COIN_VALUE_W-1:0] COIN_V3 = 5'd20;

  // Item prices in coin units, consumed by the selection/credit FSM.
  localparam logic [7:0] PRICE_ITEM0 = 8'd15;
  localparam logic [7:0] PRICE_ITEM1 = 8'd25;
  localparam logic [7:0] PRICE_ITEM2 = 8'd35;
  localparam logic [7:0] PRICE_ITEM3 = 8'd50;

  typedef enum logic [1:0] {
    BTN_L = 2'd0,
    BTN_R = 2'd1,
    BTN_C = 2'd2
  } btn_e;

  // Auto-repeat phase for a held navigation button.
  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_PERIOD = 2'd2
  } rep_state_e;

  function automatic logic [COIN_VALUE_W-1:0] coin_value_of(input logic [1:0] idx);
    logic [COIN_VALUE_W-1:0] v;
    case (idx)
      2'd0:    v = COIN_V0;
      2'd1:    v = COIN_V1;
      2'd2:    v = COIN_V2;
      default: v = COIN_V3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_button_conditioner_if.sv
// Raw switch/button inputs and conditioned event outputs of the
// vending-machine input stage. The slave side is the conditioner; the
// master side is whatever drives the raw inputs and consumes the events.
interface coin_button_conditioner_if;
  import vm_pkg::*;

  logic [NUM_COINS-1:0]    switch;
  logic                    L_button;
  logic                    R_button;
  logic                    C_button;
  logic                    coin_valid;
  logic [COIN_VALUE_W-1:0] coin_value;
  logic                    coin_ovf;
  logic                    l_pulse;
  logic                    r_pulse;
  logic                    c_pulse;

  modport master (
    output switch, L_button, R_button, C_button,
    input  coin_valid, coin_value, coin_ovf, l_pulse, r_pulse, c_pulse
  );

  modport slave (
    input  switch, L_button, R_button, C_button,
    output coin_valid, coin_value, coin_ovf, l_pulse, r_pulse, c_pulse
  );

endinterface

// File: rtl/debounce_cell.sv
// Single-bit 2-flop synchroniser followed by a saturating stability
// counter. The debounced level only flips after DEBOUNCE_CYCLES
// consecutive synchronised samples that disagree with it.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Two-stage synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stability counter; the level flips on the cycle the count would reach
  // DEBOUNCE_CYCLES, and any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/coin_button_conditioner.sv
// Vending-machine input conditioner: debounces four coin switches and the
// L/R/C buttons, turns debounced rising edges into single-cycle credit and
// navigation events, and serialises simultaneous coins one per cycle.
// Optional auto-repeat of held L/R buttons is enabled by defining
// VM_COND_AUTOREPEAT_EN; the default build emits one pulse per press.
module coin_button_conditioner
  import vm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 15,
  parameter int unsigned REPEAT_DELAY    = 10000000,
  parameter int unsigned REPEAT_PERIOD   = 4000000
) (
  input  logic                     clk,
  input  logic                     rst,
  coin_button_conditioner_if.slave bus
);

  localparam int unsigned IDX_L = BTN_BASE + int'(BTN_L);
  localparam int unsigned IDX_R = BTN_BASE + int'(BTN_R);
  localparam int unsigned IDX_C = BTN_BASE + int'(BTN_C);

  // An out-of-range parameter set elaborates this marker scope.
  if ((DEBOUNCE_CYCLES < 2) || ((2 ** CNT_W) <= DEBOUNCE_CYCLES) ||
      (REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_bad_config
  end

  logic [NUM_INPUTS-1:0] raw;
  logic [NUM_INPUTS-1:0] level;
  logic [NUM_INPUTS-1:0] level_q;
  logic [NUM_INPUTS-1:0] rise;

  assign raw = {bus.C_button, bus.R_button, bus.L_button, bus.switch};

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(level[i])
    );
  end

  // Previous debounced levels for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= '0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

  // ---------------------------------------------------------------- coins
  logic [NUM_COINS-1:0]    pending;
  logic [NUM_COINS-1:0]    pending_next;
  logic [NUM_COINS-1:0]    emit;
  logic [COIN_VALUE_W-1:0] emit_value;
  logic                    ovf_next;
  logic                    coin_valid_q;
  logic [COIN_VALUE_W-1:0] coin_value_q;
  logic                    coin_ovf_q;

  // Pick the highest pending coin, merge new rises, flag lost duplicates.
  always_comb begin
    emit       = '0;
    emit_value = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      if (pending[i]) begin
        emit       = '0;
        emit[i]    = 1'b1;
        emit_value = coin_value_of(2'(i));
      end
    end
    pending_next = (pending & ~emit) | rise[NUM_COINS-1:0];
    ovf_next     = |(rise[NUM_COINS-1:0] & pending & ~emit);
  end

  // Pending set and registered coin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      coin_valid_q <= 1'b0;
      coin_value_q <= '0;
      coin_ovf_q   <= 1'b0;
    end else begin
      pending      <= pending_next;
      coin_valid_q <= |emit;
      coin_value_q <= emit_value;
      coin_ovf_q   <= ovf_next;
    end
  end

  // -------------------------------------------------------------- buttons
  logic       evt_l;
  logic       evt_r;
  logic       evt_c;
  logic [1:0] rep;
  logic [2:0] evt_q;
  logic [2:0] pulse_q;

  // A rise on L/R is dropped if the opposite button is already high; a
  // simultaneous L+R rise sets both levels, so it cancels both sides too.
  assign evt_l = rise[IDX_L] & ~level[IDX_R];
  assign evt_r = rise[IDX_R] & ~level[IDX_L];
  assign evt_c = rise[IDX_C];

`ifdef VM_COND_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [1:0] start;
  logic [1:0] held;

  assign start = {evt_r, evt_l};
  assign held  = {level[IDX_R] & ~level[IDX_L], level[IDX_L] & ~level[IDX_R]};

  for (genvar b = 0; b < 2; b++) begin : g_rep
    rep_state_e       state;
    rep_state_e       state_nx;
    logic [REP_W-1:0] cnt;
    logic [REP_W-1:0] cnt_nx;
    logic             fire;

    // Repeat phase and cycle counter for one navigation button.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= REP_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    // Count from the accepted press; fire after the delay, then per period.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      fire     = 1'b0;
      case (state)
        REP_IDLE: begin
          if (start[b]) begin
            state_nx = REP_DELAY;
            cnt_nx   = REP_W'(1);
          end
        end
        REP_DELAY: begin
          if (!held[b]) begin
            state_nx = REP_IDLE;
            cnt_nx   = '0;
          end else if (cnt == REP_W'(REPEAT_DELAY)) begin
            fire     = 1'b1;
            state_nx = REP_PERIOD;
            cnt_nx   = REP_W'(1);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        REP_PERIOD: begin
          if (!held[b]) begin
            state_nx = REP_IDLE;
            cnt_nx   = '0;
          end else if (cnt == REP_W'(REPEAT_PERIOD)) begin
            fire   = 1'b1;
            cnt_nx = REP_W'(1);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = REP_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    assign rep[b] = fire;
  end
`else
  assign rep = '0;
`endif

  // Two register stages so button events line up with the coin path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q   <= '0;
      pulse_q <= '0;
    end else begin
      evt_q   <= {evt_c, evt_r | rep[1], evt_l | rep[0]};
      pulse_q <= evt_q;
    end
  end

  assign bus.coin_valid = coin_valid_q;
  assign bus.coin_value = coin_value_q;
  assign bus.coin_ovf   = coin_ovf_q;
  assign bus.l_pulse    = pulse_q[0];
  assign bus.r_pulse    = pulse_q[1];
  assign bus.c_pulse    = pulse_q[2];

endmodule

// File: tb/tb_coin_button_conditioner.sv
// Directed bench for coin_button_conditioner with DEBOUNCE_CYCLES=4:
// reset, glitch rejection, coin serialisation, overflow, button conflicts
// and (when VM_COND_AUTOREPEAT_EN is defined) auto-repeat timing.
module tb_coin_button_conditioner;

  typedef struct packed {
    logic       valid;
    logic [4:0] value;
    logic       ovf;
    logic       l;
    logic       r;
    logic       c;
  } out_t;

  typedef struct {
    logic [3:0] sw;
    logic       l;
    logic       r;
    logic       c;
    out_t       exp;
  } vec_t;

  localparam out_t NONE  = '0;
  localparam int   NO_EV = -1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failures = 0;

  coin_button_conditioner_if bus();

  coin_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic out_t coin(input logic [4:0] v);
    out_t o = '0;
    o.valid = 1'b1;
    o.value = v;
    return o;
  endfunction

  function automatic out_t btn(input logic l, input logic r, input logic c);
    out_t o = '0;
    o.l = l;
    o.r = r;
    o.c = c;
    return o;
  endfunction

  function automatic out_t sample();
    return {bus.coin_valid, bus.coin_value, bus.coin_ovf, bus.l_pulse, bus.r_pulse, bus.c_pulse};
  endfunction

  task automatic drive(input logic [3:0] sw, input logic l, input logic r, input logic c);
    bus.switch   = sw;
    bus.L_button = l;
    bus.R_button = r;
    bus.C_button = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int k, input out_t exp);
    out_t got = sample();
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got {valid,value,ovf,l,r,c}=%b required %b", name, k, got, exp);
    end
  endtask

  task automatic idle(input string name, input int n);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      step();
      check(name, k, NONE);
    end
  endtask

  // Hold the given inputs for 'hold' cycles, observe 'total' cycles and
  // expect exactly one event 'ev' at cycle index ev_at (NO_EV for none).
  task automatic press(input string name, input logic [3:0] sw, input logic l,
                       input logic r, input logic c, input int hold,
                       input int total, input int ev_at, input out_t ev);
    for (int k = 0; k < total; k++) begin
      if (k < hold) drive(sw, l, r, c);
      else          drive(4'b0000, 1'b0, 1'b0, 1'b0);
      step();
      check(name, k, (k == ev_at) ? ev : NONE);
    end
  endtask

  vec_t vecs[20];

  initial begin
    // Simultaneous coins: four back-to-back events in priority order.
    for (int i = 0; i < 20; i++) begin
      vecs[i].sw  = (i < 10) ? 4'b1111 : 4'b0000;
      vecs[i].l   = 1'b0;
      vecs[i].r   = 1'b0;
      vecs[i].c   = 1'b0;
      vecs[i].exp = NONE;
    end
    vecs[7].exp  = coin(5'd20);
    vecs[8].exp  = coin(5'd10);
    vecs[9].exp  = coin(5'd5);
    vecs[10].exp = coin(5'd1);

    // Reset held with a coin switch already high.
    drive(4'b0010, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("reset_hold", k, NONE);
    end
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      check("reset_release_coin5", k, (k == 7) ? coin(5'd5) : NONE);
    end
    idle("idle_a", 10);

    // Table-driven simultaneous coins.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].sw, vecs[i].l, vecs[i].r, vecs[i].c);
      step();
      check("coins_1111", i, vecs[i].exp);
    end
    idle("idle_b", 6);

    // Glitch of 3 cycles rejected, then a proper hold accepted.
    press("glitch3", 4'b0001, 1'b0, 1'b0, 1'b0, 3, 13, NO_EV, NONE);
    press("coin1_hold20", 4'b0001, 1'b0, 1'b0, 1'b0, 20, 32, 7, coin(5'd1));

    // Overflow: bit 2 rises again while pending behind bit 3.
    force dut.rise = 7'b0001100;
    @(posedge clk);
    #1;
    force dut.rise = 7'b0000100;
    @(posedge clk);
    #1;
    release dut.rise;
    check("ovf_first", 0, out_t'({1'b1, 5'd20, 1'b1, 3'b000}));
    step();
    check("ovf_second", 1, coin(5'd10));
    step();
    check("ovf_drained", 2, NONE);
    idle("idle_c", 4);

    // Buttons.
    press("lr_conflict", 4'b0000, 1'b1, 1'b1, 1'b0, 8, 20, NO_EV, NONE);
    press("l_alone", 4'b0000, 1'b1, 1'b0, 1'b0, 8, 20, 7, btn(1'b1, 1'b0, 1'b0));
    press("c_alone", 4'b0000, 1'b0, 1'b0, 1'b1, 8, 20, 7, btn(1'b0, 1'b0, 1'b1));

    // L pressed while R is held: only the R press is reported.
    for (int k = 0; k < 34; k++) begin
      drive(4'b0000, (k >= 10) && (k < 22), k < 22, 1'b0);
      step();
      check("l_while_r_held", k, (k == 7) ? btn(1'b0, 1'b1, 1'b0) : NONE);
    end
    idle("idle_d", 4);

    // Asynchronous reset while coins are draining drops the rest.
    for (int k = 0; k < 9; k++) begin
      drive(4'b1111, 1'b0, 1'b0, 1'b0);
      step();
      check("drain_before_rst", k, (k == 7) ? coin(5'd20) : (k == 8) ? coin(5'd10) : NONE);
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clears", 0, NONE);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    idle("after_rst_no_coins", 12);

`ifdef VM_COND_AUTOREPEAT_EN
    // Held R: press pulse then repeats at +10, +15, +20, +25.
    for (int k = 0; k < 45; k++) begin
      drive(4'b0000, 1'b0, k < 30, 1'b0);
      step();
      check("r_autorepeat", k,
            ((k == 7) || (k == 17) || (k == 22) || (k == 27) || (k == 32)) ?
            btn(1'b0, 1'b1, 1'b0) : NONE);
    end
    idle("idle_e", 4);

    // Reset mid-hold stops repeating at once.
    for (int k = 0; k < 20; k++) begin
      drive(4'b0000, 1'b0, 1'b1, 1'b0);
      step();
      check("r_hold_pre_rst", k, ((k == 7) || (k == 17)) ? btn(1'b0, 1'b1, 1'b0) : NONE);
    end
    rst = 1'b1;
    #1;
    check("r_rst_immediate", 0, NONE);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("r_rst_held", k, NONE);
    end
    rst = 1'b0;
    idle("r_after_rst", 12);
`else
    // Long L hold still gives exactly one pulse.
    press("l_no_repeat", 4'b0000, 1'b1, 1'b0, 1'b0, 40, 52, 7, btn(1'b1, 1'b0, 1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
